uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, giving clocks per bit (legal range 4..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal 5..9).
REQ-003 The block SHALL have parameter PARITY, default 0, selecting 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (legal 1 or 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port data_out, output, DATA_BITS wide: last received word, LSB first on the line.
REQ-009 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a new word on data_out.
REQ-010 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse, coincident with data_valid, on parity mismatch.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when any stop bit samples low.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK; PARITY is skipped when PARITY = 0.
REQ-015 IDLE -> START SHALL occur on the first cycle the synchronized rx is 0; the bit counter clears to 0.
REQ-016 In START, at counter = CLK_DIV/2 (integer division), rx = 0 SHALL go to DATA with the counter cleared, and rx = 1 SHALL return to IDLE with no output pulse (glitch rejection).
REQ-017 In DATA, PARITY and STOP, a bit SHALL be sampled when the counter reaches CLK_DIV-1; the counter then clears to 0.
REQ-018 DATA SHALL capture DATA_BITS samples, bit index 0 first, then go to PARITY (or to STOP when PARITY = 0).
REQ-019 PARITY SHALL compare the sampled bit to the XOR of the data bits (even) or its inverse (odd), record any mismatch, then go to STOP.
REQ-020 STOP SHALL sample STOP_BITS bits; after the last stop bit is sampled the FSM SHALL go to IDLE in the same cycle, so a start edge arriving immediately is accepted.
REQ-021 If all stop bits are 1: on the sampling edge of the last stop bit, data_out SHALL load the word and data_valid SHALL pulse; parity_err SHALL pulse in the same cycle if a mismatch was recorded.
REQ-022 If any stop bit is 0: frame_err SHALL pulse once when the last stop bit is sampled; data_out SHALL hold, data_valid and parity_err SHALL stay low, and the FSM SHALL enter BREAK.
REQ-023 BREAK SHALL stay until synchronized rx is 1, then go to IDLE; a continuous low line SHALL give exactly one frame_err.
REQ-024 Counters SHALL be 16 bits; bit index width SHALL be clog2(DATA_BITS+1).
REQ-025 Pulse outputs SHALL be registered and SHALL never be high for more than one consecutive cycle.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately force state = IDLE, counters = 0, data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0, and synchronizer flops = 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release the block SHALL wait for a new falling edge.

Verification (CLK_DIV = 16 unless stated)
REQ-028 8N1, send 0xA5 -> data_out = 0xA5, one data_valid pulse, no error pulses, busy falls in the same cycle.
REQ-029 PARITY = 2, send 0x07 with parity bit 1 -> data_out = 0x07 with data_valid; send 0x07 with parity bit 0 -> data_valid and parity_err pulse together.
REQ-030 STOP_BITS = 2, second stop bit low -> one frame_err pulse, no data_valid, data_out holds its previous value; hold rx low 100 cycles -> no further pulses, busy stays high until rx rises.
REQ-031 A 5-cycle low glitch on rx in IDLE -> return to IDLE, no pulses; a following valid 0x3C frame is received correctly.
REQ-032 DATA_BITS = 9, back-to-back frames 0x1FF then 0x000 with no idle gap -> two data_valid pulses with correct values.
REQ-033 rst_n pulsed low during the DATA state -> all outputs 0 at once, no pulse after release, next frame 0x55 received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver. It oversamples the line with a clock divider,
// rejects short start-bit glitches, and checks optional parity and 1 or 2 stop
// bits. A low line that persists past the stop bits is treated as a break: it
// raises one frame error and is then ignored until the line returns high.
//
// Parameters
//   CLK_DIV   : clocks per bit (4..65535)
//   DATA_BITS : data bits per frame (5..9)
//   PARITY    : 0 = none, 1 = odd, 2 = even
//   STOP_BITS : stop bits per frame (1 or 2)
//
// Ports
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   rx         : asynchronous serial input, idle high, LSB first
//   data_out   : last word received with good stop bits
//   data_valid : one-cycle pulse when data_out loads a new word
//   parity_err : one-cycle pulse alongside data_valid on parity mismatch
//   frame_err  : one-cycle pulse when any stop bit samples low
//   busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int               IDX_W         = $clog2(DATA_BITS + 1);
  localparam logic [15:0]      CNT_HALF      = 16'(CLK_DIV / 2);
  localparam logic [15:0]      CNT_LAST      = 16'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO      = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Expected parity bit for a word: even parity sends the XOR of the data,
  // odd parity sends its inverse.
  function automatic logic f_parity_exp(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_cnt;
  logic [15:0]          w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par_bad;
  logic                 w_par_bad_nxt;
  logic                 r_stop_bad;
  logic                 w_stop_bad_nxt;
  logic [DATA_BITS-1:0] r_data_out;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_busy;
  logic                 w_tick;

  assign w_tick     = (r_cnt == CNT_LAST);
  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

  // Two-flop synchronizer; flops reset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; outputs are registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_par_bad_nxt  = r_par_bad;
    w_stop_bad_nxt = r_stop_bad;
    w_data_nxt     = r_data_out;
    w_valid_nxt    = 1'b0;
    w_perr_nxt     = 1'b0;
    w_ferr_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt    = S_START;
          w_cnt_nxt      = 16'd0;
          w_idx_nxt      = IDX_ZERO;
          w_par_bad_nxt  = 1'b0;
          w_stop_bad_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        // Mid-start-bit check: a line that is already high again was a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = 16'd0;
          if (!r_rx_sync) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = 16'd0;
          // LSB arrives first, so shifting in from the top leaves it at bit 0.
          w_shift_nxt = {r_rx_sync, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_DATA_LAST) begin
            w_idx_nxt = IDX_ZERO;
            if (PARITY != 0) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt     = 16'd0;
          w_par_bad_nxt = r_rx_sync ^ f_parity_exp(r_shift);
          w_idx_nxt     = IDX_ZERO;
          w_state_nxt   = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt      = 16'd0;
          w_stop_bad_nxt = r_stop_bad | ~r_rx_sync;
          if (r_idx == IDX_STOP_LAST) begin
            if (r_stop_bad | ~r_rx_sync) begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_BREAK;
            end else begin
              // Straight to IDLE so a start bit right behind us is caught.
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_perr_nxt  = r_par_bad;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_BREAK: begin
        if (r_rx_sync) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 16'd0;
      r_idx      <= IDX_ZERO;
      r_shift    <= {DATA_BITS{1'b0}};
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
      r_data_out <= {DATA_BITS{1'b0}};
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bad  <= w_par_bad_nxt;
      r_stop_bad <= w_stop_bad_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_perr     <= w_perr_nxt;
      r_ferr     <= w_ferr_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Testbench for uart_rx_cfg: five receivers with different frame formats share
// a clock and reset; each has its own rx line driven by frame tasks.
module tb_uart_rx_cfg;

  localparam int NI = 5;
  localparam int P_DIV  [NI] = '{16, 16, 16, 16, 9};
  localparam int P_DB   [NI] = '{8, 8, 8, 9, 6};
  localparam int P_PAR  [NI] = '{0, 2, 0, 0, 1};
  localparam int P_STOP [NI] = '{1, 1, 2, 1, 2};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] rx_v;
  logic [7:0]    do0, do1, do2;
  logic [8:0]    do3;
  logic [5:0]    do4;
  logic [NI-1:0] dv_v, pe_v, fe_v, bz_v;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         dv_cnt [NI];
  int         pe_cnt [NI];
  int         fe_cnt [NI];
  int         viol   [NI];
  logic [8:0] prev_dout [NI];
  logic [NI-1:0] prev_dv, prev_pe, prev_fe, prev_bz;
  logic [8:0] exp_last [NI];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .data_out(do0), .data_valid(dv_v[0]),
    .parity_err(pe_v[0]), .frame_err(fe_v[0]), .busy(bz_v[0]));
  uart_rx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .data_out(do1), .data_valid(dv_v[1]),
    .parity_err(pe_v[1]), .frame_err(fe_v[1]), .busy(bz_v[1]));
  uart_rx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .data_out(do2), .data_valid(dv_v[2]),
    .parity_err(pe_v[2]), .frame_err(fe_v[2]), .busy(bz_v[2]));
  uart_rx_cfg #(.CLK_DIV(16), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[3]), .data_out(do3), .data_valid(dv_v[3]),
    .parity_err(pe_v[3]), .frame_err(fe_v[3]), .busy(bz_v[3]));
  uart_rx_cfg #(.CLK_DIV(9), .DATA_BITS(6), .PARITY(1), .STOP_BITS(2)) u_6o2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[4]), .data_out(do4), .data_valid(dv_v[4]),
    .parity_err(pe_v[4]), .frame_err(fe_v[4]), .busy(bz_v[4]));

  function automatic logic [8:0] dout_of(input int k);
    case (k)
      0: return {1'b0, do0};
      1: return {1'b0, do1};
      2: return {1'b0, do2};
      3: return do3;
      4: return {3'b000, do4};
      default: return 9'd0;
    endcase
  endfunction

  // Pulse monitor: counts pulses and rule violations (pulse width, pairing,
  // busy dropping with data_valid, data_out changing without data_valid).
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        dv_cnt[k]    <= 0;
        pe_cnt[k]    <= 0;
        fe_cnt[k]    <= 0;
        prev_dout[k] <= dout_of(k);
      end
      prev_dv <= '0;
      prev_pe <= '0;
      prev_fe <= '0;
      prev_bz <= '0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (dv_v[k]) dv_cnt[k] <= dv_cnt[k] + 1;
        if (pe_v[k]) pe_cnt[k] <= pe_cnt[k] + 1;
        if (fe_v[k]) fe_cnt[k] <= fe_cnt[k] + 1;
        if ((pe_v[k] && !dv_v[k]) || (fe_v[k] && dv_v[k]) ||
            (dv_v[k] && prev_dv[k]) || (pe_v[k] && prev_pe[k]) || (fe_v[k] && prev_fe[k]) ||
            (dv_v[k] && (bz_v[k] || !prev_bz[k])) ||
            (!dv_v[k] && dout_of(k) !== prev_dout[k]))
          viol[k] <= viol[k] + 1;
        prev_dout[k] <= dout_of(k);
      end
      prev_dv <= dv_v;
      prev_pe <= pe_v;
      prev_fe <= fe_v;
      prev_bz <= bz_v;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on line k; report pulse counts seen during it.
  task automatic send_frame(input int k, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops, input int gap,
                            output int dv_d, output int pe_d, output int fe_d);
    int dv0, pe0, fe0;
    dv0 = dv_cnt[k]; pe0 = pe_cnt[k]; fe0 = fe_cnt[k];
    rx_v[k] = 1'b0;
    wait_neg(P_DIV[k]);
    for (int i = 0; i < P_DB[k]; i++) begin
      rx_v[k] = d[i];
      wait_neg(P_DIV[k]);
    end
    if (P_PAR[k] != 0) begin
      rx_v[k] = pbit;
      wait_neg(P_DIV[k]);
    end
    for (int s = 0; s < P_STOP[k]; s++) begin
      rx_v[k] = stops[s];
      wait_neg(P_DIV[k]);
    end
    rx_v[k] = 1'b1;
    wait_neg(gap);
    dv_d = dv_cnt[k] - dv0;
    pe_d = pe_cnt[k] - pe0;
    fe_d = fe_cnt[k] - fe0;
  endtask

  // Reference model: frame accepted iff every stop bit is 1; parity error iff
  // accepted and the line's parity bit disagrees with the chosen parity rule.
  function automatic void model_frame(input int k, input logic [8:0] d, input logic pbit,
                                      input logic [1:0] stops, output bit ok, output bit perr,
                                      output logic [8:0] word);
    int ones;
    logic [8:0] m;
    m    = 9'((1 << P_DB[k]) - 1);
    word = d & m;
    ones = $countones(word);
    ok   = (stops[0] == 1'b1) && ((P_STOP[k] == 1) || (stops[1] == 1'b1));
    perr = 1'b0;
    if (P_PAR[k] == 1) perr = ok && (pbit != ((ones % 2) == 0));
    if (P_PAR[k] == 2) perr = ok && (pbit != ((ones % 2) == 1));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rx_v  = '1;
    wait_neg(3);
    for (int k = 0; k < NI; k++) begin
      exp_last[k] = 9'd0;
      n_checks++;
      if ({dout_of(k), dv_v[k], pe_v[k], fe_v[k], bz_v[k]} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %0h expected 0", k,
                 {dout_of(k), dv_v[k], pe_v[k], fe_v[k], bz_v[k]});
      end
    end
    #3 rst_n = 1'b1;
    wait_neg(10);
    n_checks++;
    if (bz_v !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_busy: got %0b expected 0", bz_v);
    end
  endtask

  task automatic test_8n1();
    int dv_d, pe_d, fe_d;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 4, dv_d, pe_d, fe_d);
    exp_last[0] = 9'h0A5;
    n_checks++;
    if ({dout_of(0), dv_d[3:0], pe_d[3:0], fe_d[3:0], bz_v[0]} !== {9'h0A5, 4'd1, 4'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL 8n1_A5: data=%0h dv=%0d pe=%0d fe=%0d busy=%0b expected data=a5 dv=1 pe=0 fe=0 busy=0",
               dout_of(0), dv_d, pe_d, fe_d, bz_v[0]);
    end
  endtask

  task automatic test_parity();
    int dv_d, pe_d, fe_d;
    send_frame(1, 9'h007, 1'b1, 2'b11, 4, dv_d, pe_d, fe_d);
    exp_last[1] = 9'h007;
    n_checks++;
    if ({dout_of(1), dv_d[3:0], pe_d[3:0], fe_d[3:0]} !== {9'h007, 4'd1, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL parity_good: data=%0h dv=%0d pe=%0d fe=%0d expected 7/1/0/0", dout_of(1), dv_d, pe_d, fe_d);
    end
    send_frame(1, 9'h007, 1'b0, 2'b11, 4, dv_d, pe_d, fe_d);
    n_checks++;
    if ({dout_of(1), dv_d[3:0], pe_d[3:0], fe_d[3:0]} !== {9'h007, 4'd1, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL parity_bad: data=%0h dv=%0d pe=%0d fe=%0d expected 7/1/1/0", dout_of(1), dv_d, pe_d, fe_d);
    end
  endtask

  task automatic test_frame_err();
    int dv_d, pe_d, fe_d, fe_before;
    send_frame(2, 9'h0C3, 1'b0, 2'b11, 4, dv_d, pe_d, fe_d);
    exp_last[2] = 9'h0C3;
    n_checks++;
    if ({dout_of(2), dv_d[3:0]} !== {9'h0C3, 4'd1}) begin
      n_fail++;
      $display("FAIL stop2_good: data=%0h dv=%0d expected c3/1", dout_of(2), dv_d);
    end
    // Second stop bit low, then the line stays low (break).
    send_frame(2, 9'h05A, 1'b0, 2'b01, 0, dv_d, pe_d, fe_d);
    rx_v[2] = 1'b0;
    n_checks++;
    if ({dout_of(2), dv_d[3:0], fe_d[3:0]} !== {9'h0C3, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL stop2_bad: data=%0h dv=%0d fe=%0d expected c3/0/1", dout_of(2), dv_d, fe_d);
    end
    fe_before = fe_cnt[2];
    wait_neg(100);
    n_checks++;
    if ({fe_cnt[2] - fe_before, bz_v[2]} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL break_hold: extra_fe=%0d busy=%0b expected 0/1", fe_cnt[2] - fe_before, bz_v[2]);
    end
    rx_v[2] = 1'b1;
    wait_neg(6);
    n_checks++;
    if (bz_v[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL break_release: busy=%0b expected 0", bz_v[2]);
    end
  endtask

  task automatic test_glitch();
    int dv0, fe0, dv_d, pe_d, fe_d;
    dv0 = dv_cnt[0]; fe0 = fe_cnt[0];
    rx_v[0] = 1'b0;
    wait_neg(4);
    n_checks++;
    if (bz_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: busy=%0b expected 1", bz_v[0]);
    end
    wait_neg(1);
    rx_v[0] = 1'b1;
    wait_neg(30);
    n_checks++;
    if ({dv_cnt[0] - dv0, fe_cnt[0] - fe0, bz_v[0]} !== {32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL glitch_reject: dv=%0d fe=%0d busy=%0b expected 0/0/0", dv_cnt[0] - dv0, fe_cnt[0] - fe0, bz_v[0]);
    end
    send_frame(0, 9'h03C, 1'b0, 2'b11, 4, dv_d, pe_d, fe_d);
    exp_last[0] = 9'h03C;
    n_checks++;
    if ({dout_of(0), dv_d[3:0], fe_d[3:0]} !== {9'h03C, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL glitch_then_3C: data=%0h dv=%0d fe=%0d expected 3c/1/0", dout_of(0), dv_d, fe_d);
    end
  endtask

  task automatic test_back_to_back();
    int dv_d, pe_d, fe_d;
    send_frame(3, 9'h1FF, 1'b0, 2'b11, 0, dv_d, pe_d, fe_d);
    n_checks++;
    if ({dout_of(3), dv_d[3:0]} !== {9'h1FF, 4'd1}) begin
      n_fail++;
      $display("FAIL b2b_first: data=%0h dv=%0d expected 1ff/1", dout_of(3), dv_d);
    end
    send_frame(3, 9'h000, 1'b0, 2'b11, 4, dv_d, pe_d, fe_d);
    exp_last[3] = 9'h000;
    n_checks++;
    if ({dout_of(3), dv_d[3:0], fe_d[3:0]} !== {9'h000, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_second: data=%0h dv=%0d fe=%0d expected 0/1/0", dout_of(3), dv_d, fe_d);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0, dv_d, pe_d, fe_d;
    logic [7:0] w;
    w = 8'h55;
    rx_v[0] = 1'b0;
    wait_neg(16);
    for (int i = 0; i < 3; i++) begin
      rx_v[0] = w[i];
      wait_neg(16);
    end
    n_checks++;
    if (bz_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: busy=%0b expected 1", bz_v[0]);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout_of(0), dv_v[0], pe_v[0], fe_v[0], bz_v[0]} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %0h expected 0", {dout_of(0), dv_v[0], pe_v[0], fe_v[0], bz_v[0]});
    end
    for (int k = 0; k < NI; k++) exp_last[k] = 9'd0;
    rx_v[0] = 1'b1;
    wait_neg(3);
    #3 rst_n = 1'b1;
    dv0 = dv_cnt[0]; fe0 = fe_cnt[0];
    wait_neg(40);
    n_checks++;
    if ({dv_cnt[0] - dv0, fe_cnt[0] - fe0, bz_v[0]} !== {32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_quiet: dv=%0d fe=%0d busy=%0b expected 0/0/0", dv_cnt[0] - dv0, fe_cnt[0] - fe0, bz_v[0]);
    end
    send_frame(0, 9'h055, 1'b0, 2'b11, 4, dv_d, pe_d, fe_d);
    exp_last[0] = 9'h055;
    n_checks++;
    if ({dout_of(0), dv_d[3:0]} !== {9'h055, 4'd1}) begin
      n_fail++;
      $display("FAIL post_reset_55: data=%0h dv=%0d expected 55/1", dout_of(0), dv_d);
    end
  endtask

  task automatic test_random();
    int dv_d, pe_d, fe_d, gap, r;
    bit ok, perr;
    logic [8:0] d, word;
    logic [1:0] stops;
    logic pbit;
    for (int k = 0; k < NI; k++) begin
      for (int f = 0; f < 10; f++) begin
        d    = 9'($urandom_range(0, 511));
        pbit = 1'($urandom_range(0, 1));
        r    = $urandom_range(0, 7);
        if (P_STOP[k] == 1) stops = (r == 0) ? 2'b10 : 2'b11;
        else stops = (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : (r == 2) ? 2'b00 : 2'b11;
        model_frame(k, d, pbit, stops, ok, perr, word);
        gap = ok ? $urandom_range(0, 3) : 4 + $urandom_range(0, 3);
        send_frame(k, d, pbit, stops, gap, dv_d, pe_d, fe_d);
        if (ok) exp_last[k] = word;
        n_checks++;
        if ({dout_of(k), dv_d, pe_d, fe_d} !== {exp_last[k], 32'(ok), 32'(perr), 32'(!ok)}) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: data=%0h dv=%0d pe=%0d fe=%0d expected %0h/%0d/%0d/%0d",
                   k, f, dout_of(k), dv_d, pe_d, fe_d, exp_last[k], ok, perr, !ok);
        end
      end
    end
  endtask

  task automatic test_pulse_rules();
    wait_neg(4);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (viol[k] !== 0) begin
        n_fail++;
        $display("FAIL pulse_rules[%0d]: violations=%0d expected 0", k, viol[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) viol[k] = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
